// File: rtl/mem_write_buffer.sv
// Posted-write buffer between L2 and main memory: writes drain in order, reads forward from it.
// Define MEM_WB_COALESCE_EN to merge a write into a matching non-head entry in place.
`ifndef ADDR_BITS
`define ADDR_BITS 32
`endif
`ifndef OFFSET_BITS
`define OFFSET_BITS 6
`endif
`ifndef CACHELINE_BITS
`define CACHELINE_BITS 512
`endif

module mem_write_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               up_req_valid,
  input  logic                               up_req_rw,
  input  logic [`ADDR_BITS-`OFFSET_BITS-1:0] up_req_addr,
  input  logic [`CACHELINE_BITS-1:0]         up_req_data,
  output logic                               up_req_ready,
  output logic                               up_resp_valid,
  output logic [`CACHELINE_BITS-1:0]         up_resp_data,
  output logic                               mem_req_valid,
  output logic                               mem_req_rw,
  output logic [`ADDR_BITS-`OFFSET_BITS-1:0] mem_req_addr,
  output logic [`CACHELINE_BITS-1:0]         mem_req_data,
  input  logic                               mem_req_ready,
  input  logic                               mem_resp_valid,
  input  logic [`CACHELINE_BITS-1:0]         mem_resp_data
);

  localparam int unsigned AW = `ADDR_BITS - `OFFSET_BITS;
  localparam int unsigned LW = `CACHELINE_BITS;
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StRdReq, StRdWait, StResp} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   addr_q [DEPTH];
  logic [LW-1:0]   data_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic [AW-1:0]   rd_addr_q, rd_addr_d;
  logic [LW-1:0]   resp_data_q, resp_data_d;

  logic            hit;
  logic [LW-1:0]   hit_data;
  logic [PW-1:0]   search_idx;
  logic            drain_valid, mem_pop, rdy_wr;
  logic            wr_acc, rd_acc, push, coalesce;
`ifdef MEM_WB_COALESCE_EN
  logic            coal_hit;
  logic [PW-1:0]   coal_idx;
`endif

  // Associative search over valid entries, oldest to youngest, on pre-pop contents.
  always_comb begin
    hit        = 1'b0;
    hit_data   = '0;
    search_idx = rd_ptr_q;
`ifdef MEM_WB_COALESCE_EN
    coal_hit   = 1'b0;
    coal_idx   = '0;
`endif
    for (int unsigned i = 0; i < DEPTH; i++) begin
      search_idx = rd_ptr_q + PW'(i);
      if (CW'(i) < count_q && addr_q[search_idx] == up_req_addr) begin
        hit      = 1'b1;
        hit_data = data_q[search_idx];
`ifdef MEM_WB_COALESCE_EN
        if (i != 0) begin
          coal_hit = 1'b1;
          coal_idx = search_idx;
        end
`endif
      end
    end
  end

  always_comb begin
    drain_valid  = (state_q == StIdle) && (count_q != '0);
    mem_pop      = drain_valid && mem_req_ready;
    rdy_wr       = reset_n && (state_q == StIdle) && (count_q < DepthC);
    // A read with writes pending must see memory ready so it can never overtake the drain.
    up_req_ready = up_req_rw ? rdy_wr : (rdy_wr && (count_q == '0 || mem_req_ready));
    wr_acc       = up_req_valid && up_req_ready && up_req_rw;
    rd_acc       = up_req_valid && up_req_ready && !up_req_rw;
`ifdef MEM_WB_COALESCE_EN
    coalesce     = wr_acc && coal_hit;
`else
    coalesce     = 1'b0;
`endif
    push         = wr_acc && !coalesce;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr_q] <= up_req_addr;
      data_q[wr_ptr_q] <= up_req_data;
    end
`ifdef MEM_WB_COALESCE_EN
    if (coalesce) begin
      data_q[coal_idx] <= up_req_data;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_addr_q   <= '0;
      resp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_q + PW'(push);
      rd_ptr_q    <= rd_ptr_q + PW'(mem_pop);
      count_q     <= count_q + CW'(push) - CW'(mem_pop);
      rd_addr_q   <= rd_addr_d;
      resp_data_q <= resp_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    resp_data_d = resp_data_q;
    case (state_q)
      StIdle: begin
        if (rd_acc) begin
          if (hit) begin
            resp_data_d = hit_data;
            state_d     = StResp;
          end else begin
            rd_addr_d   = up_req_addr;
            state_d     = StRdReq;
          end
        end
      end
      StRdReq: begin
        if (mem_req_ready) state_d = StRdWait;
      end
      StRdWait: begin
        if (mem_resp_valid) begin
          resp_data_d = mem_resp_data;
          state_d     = StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mem_req_valid = 1'b0;
    mem_req_rw    = 1'b0;
    mem_req_addr  = '0;
    mem_req_data  = '0;
    if (state_q == StRdReq) begin
      mem_req_valid = 1'b1;
      mem_req_addr  = rd_addr_q;
    end else if (drain_valid) begin
      mem_req_valid = 1'b1;
      mem_req_rw    = 1'b1;
      mem_req_addr  = addr_q[rd_ptr_q];
      mem_req_data  = data_q[rd_ptr_q];
    end
    up_resp_valid = (state_q == StResp);
    up_resp_data  = up_resp_valid ? resp_data_q : '0;
  end

endmodule

// File: doc/mem_write_buffer.md
# mem_write_buffer

Posted-write buffer between the L2 main-memory port and main memory. L2 writebacks are absorbed into a small FIFO, so L2 no longer stalls on memory write latency. The FIFO drains to memory in the background. Reads that hit a buffered line are answered from the buffer. Reads that miss are forwarded to memory.

## Interface
Parameters:
- `DEPTH`, default 4: number of line entries; power of two, ≥2.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `up_req_valid`  in  1  request from L2.
- `up_req_rw`  in  1  0: read; 1: write.
- `up_req_addr`  in  `ADDR_BITS-`OFFSET_BITS  line address.
- `up_req_data`  in  `CACHELINE_BITS  write data.
- `up_req_ready`  out  1  request accepted when valid&&ready.
- `up_resp_valid`  out  1  one-cycle read-data pulse.
- `up_resp_data`  out  `CACHELINE_BITS  read data.
- `mem_req_valid`, `mem_req_rw`, `mem_req_addr`, `mem_req_data`  out  1/1/addr/line  request to memory.
- `mem_req_ready`  in  1  memory accepts when valid&&ready.
- `mem_resp_valid`  in  1  memory read data valid; memory returns data for reads only.
- `mem_resp_data`  in  `CACHELINE_BITS  memory read data.

## Operation
- State is the FIFO of {addr, data} entries plus `count` (width clog2(DEPTH)+1) and the FSM.
- FSM states:
  - IDLE (reset state).
  - RD_REQ: read miss presented to memory.
  - RD_WAIT: waiting for read data.
  - RESP: returning data to L2.
- `up_req_ready` rules:
  - Write: ready when state==IDLE && count<DEPTH.
  - Read: ready when state==IDLE && count<DEPTH && (count==0 || mem_req_ready).
  - `up_req_ready` therefore depends combinationally on `up_req_rw` and `mem_req_ready`.
- Drain: in IDLE with count>0, the head entry is presented as a write (valid=1, rw=1, head addr/data).
  - Once asserted, it holds stable until mem_req_ready.
  - On the handshake the head pops and the write is complete; there is no memory response.
- Drain is paused in RD_REQ, RD_WAIT and RESP.
- Accepted write: pushed at the tail. count' = count + push − pop. A push and a pop may occur in the same cycle.
- Accepted read, address check: compared against all valid entries, using pre-pop contents for that cycle.
  - Hit: latch data of the youngest matching entry, go to RESP.
  - Miss: latch the address, go to RD_REQ.
- RD_REQ: mem_req_valid=1, rw=0, addr=latched, data=0. On mem_req_ready, go to RD_WAIT.
- RD_WAIT: on mem_resp_valid, latch mem_resp_data and go to RESP.
- RESP: up_resp_valid=1 with the latched data for exactly one cycle, then IDLE.
- mem_resp_valid outside RD_WAIT is ignored.
- Ordering: a read never bypasses a buffered write to the same line; it gets forwarded data instead.
  - Writes to different lines may be pending while a read miss is outstanding.
- When mem_req_valid=0, mem_req_rw/addr/data drive 0.

## Timing
- Reset (asynchronous, immediate): FSM=IDLE, count=0, pointers=0, latched data/addr=0.
- Output values while reset_n=0: up_req_ready=0, up_resp_valid=0, up_resp_data=0, mem_req_valid=0, mem_req_rw=0, mem_req_addr=0, mem_req_data=0.
- After reset release: up_req_ready=1 in the first cycle.
- Reset mid-read drops the transaction; a late mem_resp_valid is ignored.
- Write accept: zero bubble. One write per cycle while count<DEPTH.
- First drain: mem_req_valid rises the cycle after the push, because it is gated by registered count.
- Read hit latency: accepted at cycle T, up_resp_valid at T+1.
- Read miss latency: accepted at T; mem_req_valid at T+1; memory accepts at R; mem_resp_valid at M>R; up_resp_valid at M+1.
- Full: count==DEPTH deasserts up_req_ready in that cycle. A pop that cycle re-enables ready the next cycle.
- Pointers wrap modulo DEPTH.

## Configuration
- `MEM_WB_COALESCE_EN` defined:
  - An accepted write whose address matches a non-head valid entry overwrites that entry's data in place: no push, count unchanged.
  - The head entry is never a coalescing target while presented to memory; a match on the head appends a new entry.
  - At most one non-head entry per address exists.
- Undefined: every write appends. Duplicate addresses can coexist, and read forwarding selects the youngest match.

## Test plan
- Reset, then write A=0x10 data=D1 with mem_req_ready=1 -> mem_req_valid at T+1 with rw=1, addr=0x10, data=D1; count returns to 0.
- mem_req_ready=0, push 4 writes 0x1..0x4 -> up_req_ready=0 when count=4. Release ready -> memory sees 0x1, 0x2, 0x3, 0x4 in order; head valid/data stable while stalled.
- Buffer 0x20=D2 (memory stalled), read 0x20 -> up_resp_valid one cycle later with D2; no mem read issued.
- Empty buffer, read 0x30, memory accepts at once and returns D3 three cycles later -> up_resp_valid at mem_resp+1 with D3; a spurious mem_resp_valid in IDLE is ignored.
- Write 0x40=D4, 0x41, then 0x40=D5 with memory stalled:
  - With `MEM_WB_COALESCE_EN` and 0x40 not head: count=2.
  - Without the macro: count=3.
  - A read of 0x40 returns D5 in both cases.
- Assert reset_n low during RD_WAIT, then return mem_resp_valid -> all outputs 0 during reset; no up_resp_valid afterward; count=0.
